two_level_branch_predictor: RTL and testbench

- Parametrised two-level direction predictor for the RSD fetch stage.
- Generalises the fixed compile-time gshare / SAg choice into one block:
  - MODE selects a global-history scheme or a per-address-history scheme.
  - Lane count, table depths and history width are parameters.
- Adds a table-initialisation FSM, speculative global history and misprediction recovery.
- Sits beside the BTB: fetch queries it, commit trains it.

---
 rtl/two_level_branch_predictor.sv | 202 ++++++++++++++++++++
 tb/tb_two_level_branch_predictor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/two_level_branch_predictor.sv
// rtl/two_level_branch_predictor.sv - two-level (gshare / SAg) direction predictor with table init FSM
// Optional RSD_BPRED_STATS_EN adds saturating lookup / mispredict counters.
module two_level_branch_predictor #(
    parameter int MODE          = 0,
    parameter int LANE_NUM      = 2,
    parameter int PHT_ENTRY_NUM = 2048,
    parameter int BHT_ENTRY_NUM = 1024,
    parameter int HIST_WIDTH    = 5,
    parameter int PC_WIDTH      = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           ready,
    input  logic [LANE_NUM-1:0]            predReq,
    input  logic [LANE_NUM*PC_WIDTH-1:0]   predPC,
    output logic [LANE_NUM-1:0]            predValid,
    output logic [LANE_NUM-1:0]            predTaken,
    output logic [LANE_NUM*HIST_WIDTH-1:0] predHist,
    input  logic                           updValid,
    input  logic [PC_WIDTH-1:0]            updPC,
    input  logic                           updTaken,
    input  logic                           updMispred,
    input  logic [HIST_WIDTH-1:0]          updHist
`ifdef RSD_BPRED_STATS_EN
    ,
    output logic [31:0]                    statLookups,
    output logic [31:0]                    statMispreds
`endif
);

    localparam int PHT_IDX  = $clog2(PHT_ENTRY_NUM);
    localparam int BHT_IDX  = $clog2(BHT_ENTRY_NUM);
    localparam int INIT_NUM = (PHT_ENTRY_NUM > BHT_ENTRY_NUM) ? PHT_ENTRY_NUM : BHT_ENTRY_NUM;
    localparam int INIT_W   = $clog2(INIT_NUM);
    localparam logic [INIT_W:0] PHT_LIM = (INIT_W+1)'(PHT_ENTRY_NUM);
    localparam logic [INIT_W:0] BHT_LIM = (INIT_W+1)'(BHT_ENTRY_NUM);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [INIT_W-1:0]              init_idx_q, init_idx_d;
    logic [HIST_WIDTH-1:0]          ghr_q, ghr_d;
    logic [LANE_NUM-1:0]            pred_valid_q, pred_valid_d;
    logic [LANE_NUM-1:0]            pred_taken_q, pred_taken_d;
    logic [LANE_NUM*HIST_WIDTH-1:0] pred_hist_q, pred_hist_d;

    logic [1:0]            pht_q [PHT_ENTRY_NUM];
    logic [HIST_WIDTH-1:0] bht_q [BHT_ENTRY_NUM];

    logic [HIST_WIDTH-1:0] hist_run;
    logic [PC_WIDTH-1:0]   lane_pc;
    logic [HIST_WIDTH-1:0] lane_hist;
    logic                  lane_taken;
    logic                  run;
    logic                  upd_en;
    logic [PHT_IDX-1:0]    upd_idx;
    logic [1:0]            upd_ctr, upd_ctr_next;

    // MODE0 folds history into the word-aligned PC; MODE1 appends it below the PC bits.
    function automatic logic [PHT_IDX-1:0] pht_index(input logic [PC_WIDTH-1:0] pc,
                                                     input logic [HIST_WIDTH-1:0] hist);
        if (MODE == 0) return PHT_IDX'(pc >> 2) ^ PHT_IDX'(hist);
        else           return PHT_IDX'({pc >> 2, hist});
    endfunction

    function automatic logic [BHT_IDX-1:0] bht_index(input logic [PC_WIDTH-1:0] pc);
        return BHT_IDX'(pc >> 2);
    endfunction

    assign run    = (state_q == S_RUN);
    assign upd_en = run && updValid;

    // Lookup: later lanes see the history already shifted by earlier requesting lanes.
    always_comb begin
        hist_run     = ghr_q;
        lane_pc      = '0;
        lane_hist    = '0;
        lane_taken   = 1'b0;
        pred_valid_d = '0;
        pred_taken_d = '0;
        pred_hist_d  = '0;
        for (int k = 0; k < LANE_NUM; k++) begin
            lane_pc = predPC[k*PC_WIDTH +: PC_WIDTH];
            if (MODE == 0) lane_hist = hist_run;
            else           lane_hist = bht_q[bht_index(lane_pc)];
            lane_taken = pht_q[pht_index(lane_pc, lane_hist)][1];
            if (predReq[k] && run) begin
                pred_valid_d[k]                          = 1'b1;
                pred_taken_d[k]                          = lane_taken;
                pred_hist_d[k*HIST_WIDTH +: HIST_WIDTH]  = lane_hist;
                hist_run = {hist_run[HIST_WIDTH-2:0], lane_taken};
            end
        end
    end

    always_comb begin
        upd_idx = pht_index(updPC, updHist);
        upd_ctr = pht_q[upd_idx];
        if (updTaken) upd_ctr_next = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
        else          upd_ctr_next = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ghr_d      = ghr_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == INIT_W'(INIT_NUM - 1)) begin
                    state_d    = S_RUN;
                    init_idx_d = '0;
                end
            end
            S_RUN: begin
                ghr_d = hist_run;
                if (updValid && updMispred) ghr_d = {updHist[HIST_WIDTH-2:0], updTaken};
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_idx_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= '0;
            pred_taken_q <= '0;
            pred_hist_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

    // Tables carry no reset; the INIT sweep gives them their defined contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                if ({1'b0, init_idx_q} < PHT_LIM) pht_q[init_idx_q[PHT_IDX-1:0]] <= 2'b01;
            end else if (upd_en) begin
                pht_q[upd_idx] <= upd_ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                if ({1'b0, init_idx_q} < BHT_LIM) bht_q[init_idx_q[BHT_IDX-1:0]] <= '0;
            end else if (upd_en && MODE == 1) begin
                bht_q[bht_index(updPC)] <= {updHist[HIST_WIDTH-2:0], updTaken};
            end
        end
    end

    assign ready     = run;
    assign predValid = pred_valid_q;
    assign predTaken = pred_taken_q;
    assign predHist  = pred_hist_q;

`ifdef RSD_BPRED_STATS_EN
    localparam int CNT_W = $clog2(LANE_NUM + 1);

    logic [31:0]      stat_lookups_q, stat_lookups_d;
    logic [31:0]      stat_mispreds_q, stat_mispreds_d;
    logic [CNT_W-1:0] req_cnt;
    logic [32:0]      lookup_sum;

    always_comb begin
        req_cnt = '0;
        for (int k = 0; k < LANE_NUM; k++) req_cnt = req_cnt + CNT_W'(predReq[k]);
        lookup_sum      = {1'b0, stat_lookups_q} + 33'(req_cnt);
        stat_lookups_d  = stat_lookups_q;
        stat_mispreds_d = stat_mispreds_q;
        if (run) begin
            stat_lookups_d = lookup_sum[32] ? 32'hFFFF_FFFF : lookup_sum[31:0];
            if (updValid && updMispred && stat_mispreds_q != 32'hFFFF_FFFF)
                stat_mispreds_d = stat_mispreds_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups_q  <= '0;
            stat_mispreds_q <= '0;
        end else begin
            stat_lookups_q  <= stat_lookups_d;
            stat_mispreds_q <= stat_mispreds_d;
        end
    end

    assign statLookups  = stat_lookups_q;
    assign statMispreds = stat_mispreds_q;
`endif

endmodule

// File: tb/tb_two_level_branch_predictor.sv
// tb/tb_two_level_branch_predictor.sv - scoreboard bench for gshare and SAg predictor instances
module tb_two_level_branch_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        ready0, ready1;
    logic [1:0]  req0, req1, val0, val1, tak0, tak1;
    logic [63:0] pc0, pc1;
    logic [9:0]  hist0, hist1;
    logic        uv0, uv1, ut0, ut1, um0, um1;
    logic [31:0] upc0, upc1;
    logic [4:0]  uh0, uh1;
`ifdef RSD_BPRED_STATS_EN
    logic [31:0] sl0, sm0, sl1, sm1;
`endif

    two_level_branch_predictor #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .predReq(req0), .predPC(pc0), .predValid(val0), .predTaken(tak0), .predHist(hist0),
        .updValid(uv0), .updPC(upc0), .updTaken(ut0), .updMispred(um0), .updHist(uh0)
`ifdef RSD_BPRED_STATS_EN
        , .statLookups(sl0), .statMispreds(sm0)
`endif
    );

    two_level_branch_predictor #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .predReq(req1), .predPC(pc1), .predValid(val1), .predTaken(tak1), .predHist(hist1),
        .updValid(uv1), .updPC(upc1), .updTaken(ut1), .updMispred(um1), .updHist(uh1)
`ifdef RSD_BPRED_STATS_EN
        , .statLookups(sl1), .statMispreds(sm1)
`endif
    );

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] taken;
        logic [9:0] hist;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit sel, input logic [1:0] req, input logic [31:0] pa, input logic [31:0] pb,
                         input logic uv, input logic [31:0] upc, input logic ut, input logic um,
                         input logic [4:0] uh, input logic [1:0] et, input logic [4:0] eh0,
                         input logic [4:0] eh1);
        exp_t e;
        e.valid = req;
        e.taken = et;
        e.hist  = {eh1, eh0};
        if (sel == 1'b0) begin
            req0 = req; pc0 = {pb, pa}; uv0 = uv; upc0 = upc; ut0 = ut; um0 = um; uh0 = uh;
            if (req != 2'b00) q0.push_back(e);
        end else begin
            req1 = req; pc1 = {pb, pa}; uv1 = uv; upc1 = upc; ut1 = ut; um1 = um; uh1 = uh;
            if (req != 2'b00) q1.push_back(e);
        end
        tick();
        req0 = 2'b00; uv0 = 1'b0; um0 = 1'b0;
        req1 = 2'b00; uv1 = 1'b0; um1 = 1'b0;
    endtask

    task automatic upd0(input logic [31:0] pc, input logic t, input logic m, input logic [4:0] h);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, pc, t, m, h, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic look0(input logic [31:0] pc, input logic et, input logic [4:0] eh);
        cycle(1'b0, 2'b01, pc, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, {1'b0, et}, eh, 5'd0);
    endtask

    // Scratch-PC mispredict forces GHR back to zero without touching tested counters.
    task automatic look_rec0(input logic [31:0] pc, input logic et);
        look0(pc, et, 5'd0);
        upd0(32'hF00, 1'b0, 1'b1, 5'd0);
    endtask

    task automatic do_init(input string tag);
        int  n;
        bit  seen_valid;
        req0 = 2'b11; pc0 = {32'h104, 32'h100};
        req1 = 2'b11; pc1 = {32'h80, 32'h40};
        rst = 1'b0;
        n = 0;
        seen_valid = 1'b0;
        while (!ready0 && n < 3000) begin
            tick();
            n++;
            if (val0 != 2'b00 || val1 != 2'b00) seen_valid = 1'b1;
        end
        check({tag, "_init_cycles"}, n, 2048);
        check({tag, "_init_no_valid"}, 32'(seen_valid), 0);
        check({tag, "_ready1"}, 32'(ready1), 1);
        // Freshly initialised tables: every counter weakly not-taken, all history zero.
        q0.push_back('{valid: 2'b11, taken: 2'b00, hist: 10'd0});
        q1.push_back('{valid: 2'b11, taken: 2'b00, hist: 10'd0});
        tick();
        req0 = 2'b00;
        req1 = 2'b00;
    endtask

    function automatic logic [4:0] sag_hist(input int n);
        if (n < 0)  return 5'b00000;
        if (n == 0) return 5'b00001;
        if (n == 1) return 5'b00010;
        if (n == 2) return 5'b00101;
        if (n == 3) return 5'b01010;
        return (n % 2 == 0) ? 5'b10101 : 5'b01010;
    endfunction

    initial begin
        rst = 1'b1;
        req0 = '0; pc0 = '0; uv0 = 1'b0; upc0 = '0; ut0 = 1'b0; um0 = 1'b0; uh0 = '0;
        req1 = '0; pc1 = '0; uv1 = 1'b0; upc1 = '0; ut1 = 1'b0; um1 = 1'b0; uh1 = '0;
        fork
            begin : monitor
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (val0 !== 2'b00) begin
                        if (q0.size() == 0) check("sb0_spurious", 32'(val0), 0);
                        else begin
                            e = q0.pop_front();
                            check("sb0_valid", 32'(val0), 32'(e.valid));
                            check("sb0_taken", 32'(tak0 & e.valid), 32'(e.taken));
                            check("sb0_hist", 32'(hist0 & {{5{e.valid[1]}}, {5{e.valid[0]}}}), 32'(e.hist));
                        end
                    end
                    if (val1 !== 2'b00) begin
                        if (q1.size() == 0) check("sb1_spurious", 32'(val1), 0);
                        else begin
                            e = q1.pop_front();
                            check("sb1_valid", 32'(val1), 32'(e.valid));
                            check("sb1_taken", 32'(tak1 & e.valid), 32'(e.taken));
                            check("sb1_hist", 32'(hist1 & {{5{e.valid[1]}}, {5{e.valid[0]}}}), 32'(e.hist));
                        end
                    end
                end
            end
            begin : stimulus
                tick();
                tick();
                check("rst_ready", 32'(ready0), 0);
                check("rst_valid", 32'(val0), 0);
                do_init("first");

                // Counter at PC 0x100 / hist 0 walks 01 -> 10 -> 11(sat) -> 00(sat) -> 10.
                upd0(32'h100, 1'b1, 1'b0, 5'd0);
                look_rec0(32'h100, 1'b1);
                upd0(32'h100, 1'b1, 1'b0, 5'd0);
                upd0(32'h100, 1'b1, 1'b0, 5'd0);
                look_rec0(32'h100, 1'b1);
                upd0(32'h100, 1'b0, 1'b0, 5'd0);
                look_rec0(32'h100, 1'b1);
                upd0(32'h100, 1'b0, 1'b0, 5'd0);
                look_rec0(32'h100, 1'b0);
                upd0(32'h100, 1'b0, 1'b0, 5'd0);
                upd0(32'h100, 1'b0, 1'b0, 5'd0);
                upd0(32'h100, 1'b1, 1'b0, 5'd0);
                upd0(32'h100, 1'b1, 1'b0, 5'd0);
                look_rec0(32'h100, 1'b1);

                // Speculative GHR across lanes, then mispredict recovery.
                cycle(1'b0, 2'b11, 32'h100, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 2'b11, 5'b00000, 5'b00001);
                look0(32'h200, 1'b0, 5'b00011);
                upd0(32'hF00, 1'b0, 1'b1, 5'b00000);
                look0(32'h200, 1'b0, 5'b00000);

                // Read-before-write on the same PHT entry.
                cycle(1'b0, 2'b01, 32'h300, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
                look0(32'h300, 1'b1, 5'd0);

                // Recovery wins over the same-cycle speculative shift.
                cycle(1'b0, 2'b01, 32'h100, 32'h0, 1'b1, 32'hF00, 1'b1, 1'b1, 5'b00100, 2'b00, 5'b00001, 5'd0);
                look0(32'h200, 1'b0, 5'b01001);

                // Per-address history: alternating T,N at PC 0x40; PC 0x80 stays untrained.
                for (int n = 0; n < 32; n++) begin
                    cycle(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 32'h40, (n % 2 == 0), 1'b0, sag_hist(n - 1),
                          2'b00, 5'd0, 5'd0);
                    cycle(1'b1, 2'b11, 32'h40, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0,
                          {1'b0, (n >= 5 && n % 2 == 1)}, sag_hist(n), 5'd0);
                end

                // Set GHR to 10101, then reset mid-run.
                upd0(32'hF00, 1'b1, 1'b1, 5'b01010);
                rst = 1'b1;
                tick();
                check("midrun_ready", 32'(ready0), 0);
                check("midrun_valid", 32'(val0), 0);
                do_init("midrun");

                tick();
                tick();
                tick();
                done = 1'b1;
                tick();
                check("sb0_drain", q0.size(), 0);
                check("sb1_drain", q1.size(), 0);
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
